// File: rtl/iterative_divider_vr.sv
// Multi-cycle restoring divider with valid/ready on operands and results.
// Signed mode divides magnitudes and fixes up signs on the way into DONE.
module iterative_divider_vr #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_accept;
    logic             w_sgn;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div0;
    logic             w_last;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_borrow;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign in_rdy      = (r_state == S_IDLE) & ~rst;
    assign out_vld     = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

    assign w_accept = in_vld & in_rdy;
    assign w_sgn    = SIGNED_EN & is_signed;
    assign w_a_neg  = w_sgn & dividend[WIDTH-1];
    assign w_b_neg  = w_sgn & divisor[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -dividend : dividend;
    assign w_b_mag  = w_b_neg ? -divisor : divisor;
    assign w_div0   = (divisor == '0);
    assign w_last   = (r_cnt == '0);

    // One restoring step: shift in the next dividend bit, try to subtract.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {2'b00, r_dvs};
    assign w_borrow  = w_diff[WIDTH+1];
    assign w_rem_nxt = w_borrow ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};

    // Truncating-division sign fix-up applied to the final step's result.
    assign w_q_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fix = r_neg_r ? -w_rem_nxt[WIDTH-1:0]
                             : w_rem_nxt[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_div0 ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= CW'(WIDTH - 1);
                        if (w_div0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (w_last) begin
                        r_quotient  <= w_q_fix;
                        r_remainder <= w_r_fix;
                        r_dbz       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider_vr.sv
// Testbench for iterative_divider_vr: directed cases, reset abort and
// randomized operations checked against an integer-arithmetic model.
module tb_iterative_divider_vr;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_vld;
    logic         in_rdy;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         is_signed;
    logic         out_vld;
    logic         out_rdy;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    int total = 0;
    int bad   = 0;

    iterative_divider_vr #(
        .WIDTH    (W),
        .SIGNED_EN(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .dividend   (dividend),
        .divisor    (divisor),
        .is_signed  (is_signed),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Truncating division on plain integers; zero divisor by definition.
    function automatic void model(input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  input logic s,
                                  output logic [W-1:0] q,
                                  output logic [W-1:0] r,
                                  output logic dz);
        int ia;
        int ib;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            if (s) begin
                ia = int'($signed(a));
                ib = int'($signed(b));
            end else begin
                ia = int'(a);
                ib = int'(b);
            end
            q  = W'(ia / ib);
            r  = W'(ia % ib);
            dz = 1'b0;
        end
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input int hold,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz);
        int   lat;
        logic seen;
        logic rdy_hi;
        @(negedge clk);
        out_rdy   = (hold == 0);
        in_vld    = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        #1;
        chk("in_rdy_idle", in_rdy, 1);
        @(posedge clk);
        #1;
        in_vld    = 1'b0;
        dividend  = W'($urandom);
        divisor   = W'($urandom);
        is_signed = 1'($urandom);
        lat    = 0;
        seen   = 1'b0;
        rdy_hi = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (in_rdy) rdy_hi = 1'b1;
            if (out_vld) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        chk("latency", lat, edz ? 1 : W + 1);
        chk("in_rdy_busy", rdy_hi, 0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, edz);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_vld", out_vld, 1);
            chk("hold_q", quotient, eq);
            chk("hold_r", remainder, er);
            chk("hold_rdy", in_rdy, 0);
            chk("hold_busy", busy, 1);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        chk("vld_drop", out_vld, 0);
        chk("in_rdy_after", in_rdy, 1);
    endtask

    initial begin
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        logic         mdz;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic         vld_seen;

        rst       = 1'b1;
        in_vld    = 1'b0;
        out_rdy   = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vld", out_vld, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_rdy", in_rdy, 0);
        rst = 1'b0;
        #1;
        chk("in_rdy_post_rst", in_rdy, 1);

        run_op(8'd200, 8'd7, 1'b0, 0, 8'd28, 8'd4, 1'b0);
        run_op(8'hF9, 8'h02, 1'b1, 0, 8'hFD, 8'hFF, 1'b0);
        run_op(8'h07, 8'hFE, 1'b1, 0, 8'hFD, 8'h01, 1'b0);
        run_op(8'hF9, 8'h02, 1'b0, 0, 8'd124, 8'd1, 1'b0);
        run_op(8'h55, 8'h00, 1'b1, 0, 8'hFF, 8'h55, 1'b1);
        run_op(8'h55, 8'h00, 1'b0, 0, 8'hFF, 8'h55, 1'b1);
        run_op(8'h80, 8'hFF, 1'b1, 0, 8'h80, 8'h00, 1'b0);
        run_op(8'd100, 8'd9, 1'b0, 5, 8'd11, 8'd1, 1'b0);
        run_op(8'd50, 8'd5, 1'b0, 0, 8'd10, 8'd0, 1'b0);

        @(negedge clk);
        out_rdy  = 1'b1;
        in_vld   = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd3;
        is_signed = 1'b0;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rdy_in_rst", in_rdy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_rdy", in_rdy, 1);
        chk("abort_busy", busy, 0);
        vld_seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_vld) vld_seen = 1'b1;
        end
        chk("abort_no_vld", vld_seen, 0);
        run_op(8'd77, 8'd6, 1'b0, 0, 8'd12, 8'd5, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rs, mq, mr, mdz);
            run_op(ra, rb, rs, $urandom_range(0, 2), mq, mr, mdz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
